// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide sequencing controller:
// MDU opcode encoding, controller state encoding and default latencies.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Loadable latency down-counter: load takes priority over decrement, clear
// over both; the count saturates at zero.
module mdu_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         one_hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign one_hit_o = (cnt_q == W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencing controller for the shared multiply/divide unit in E.
// Optional feature: define MDU_CANCEL_EN to let 'cancel' abort or suppress ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic [3:0] e_md_op,
    input  logic       d_md_use,
    input  logic       cancel,
    output logic       mdu_start,
    output logic [3:0] mdu_op,
    output logic       mdu_busy,
    output logic       hilo_commit,
    output logic       hi_we,
    output logic       lo_we,
    output logic       stall_d
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       op_q;
    logic [3:0]       op_d;

    logic             cnt_load;
    logic             cnt_clear;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_one;

    logic             cancel_act;
    logic             start_c;
    logic             commit_c;
    logic             hi_we_c;
    logic             lo_we_c;

`ifdef MDU_CANCEL_EN
    assign cancel_act = cancel;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
    assign cancel_act    = 1'b0;
`endif

    mdu_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .clear_i    (cnt_clear),
        .load_val_i (cnt_load_val),
        .value_o    (cnt_value),
        .one_hit_o  (cnt_one)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        start_c      = 1'b0;
        commit_c     = 1'b0;
        hi_we_c      = 1'b0;
        lo_we_c      = 1'b0;
        cnt_load     = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                // Decode is gated by reset so every output stays low while it is held.
                if (!reset && !cancel_act && e_valid) begin
                    if (is_mul(e_md_op) || is_div(e_md_op)) begin
                        start_c      = 1'b1;
                        op_d         = e_md_op;
                        cnt_load     = 1'b1;
                        cnt_load_val = is_mul(e_md_op) ? MUL_LOAD : DIV_LOAD;
                        state_d      = ST_RUN;
                    end
                    hi_we_c = (e_md_op == OP_MTHI);
                    lo_we_c = (e_md_op == OP_MTLO);
                end
            end
            ST_RUN: begin
                if (cancel_act) begin
                    cnt_clear = 1'b1;
                    op_d      = OP_NONE;
                    state_d   = ST_IDLE;
                end else if (cnt_one || cnt_value == '0) begin
                    // A zero count here is unreachable; it only guards against lock-up.
                    commit_c = cnt_one;
                    op_d     = OP_NONE;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                op_d    = OP_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign mdu_start   = start_c;
    assign mdu_op      = start_c ? e_md_op : op_q;
    assign mdu_busy    = start_c | (state_q == ST_RUN);
    assign hilo_commit = commit_c;
    assign hi_we       = hi_we_c;
    assign lo_we       = lo_we_c;
    assign stall_d     = d_md_use & mdu_busy;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl; expected commit cycles are queued at issue
// time and popped when the controller is due to commit.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       e_valid;
    logic [3:0] e_md_op;
    logic       d_md_use;
    logic       cancel;
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic       mdu_busy;
    logic       hilo_commit;
    logic       hi_we;
    logic       lo_we;
    logic       stall_d;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int commit_q[$];

    mdu_ctrl #(
        .MUL_LAT (ML),
        .DIV_LAT (DL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .e_valid     (e_valid),
        .e_md_op     (e_md_op),
        .d_md_use    (d_md_use),
        .cancel      (cancel),
        .mdu_start   (mdu_start),
        .mdu_op      (mdu_op),
        .mdu_busy    (mdu_busy),
        .hilo_commit (hilo_commit),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .stall_d     (stall_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle's inputs just after the edge, return at the falling edge to sample.
    task automatic drive(input logic v, input logic [3:0] op, input logic du, input logic c);
        @(posedge clk);
        #1;
        e_valid  = v;
        e_md_op  = op;
        d_md_use = du;
        cancel   = c;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        e_valid  = 1'b1;
        e_md_op  = OP_MULT;
        d_md_use = 1'b1;
        cancel   = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mdu_start, mdu_busy, hilo_commit, hi_we, lo_we, stall_d} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=000000",
                     {mdu_start, mdu_busy, hilo_commit, hi_we, lo_we, stall_d});
        end
        total++;
        if (mdu_op !== OP_NONE) begin
            bad++;
            $display("FAIL reset_op got=%0d want=0", mdu_op);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        e_valid  = 1'b0;
        e_md_op  = OP_NONE;
        d_md_use = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int  t0;
        logic exp_busy, exp_c;
        t0 = 0;
        for (int k = 0; k <= ML + 1; k++) begin
            drive(k == 0, OP_MULT, 1'b0, 1'b0);
            if (k == 0) begin
                t0 = cyc;
                commit_q.push_back(cyc + ML - 1);
            end
            exp_busy = (cyc - t0) < ML;
            total++;
            if (mdu_start !== (k == 0)) begin
                bad++;
                $display("FAIL mult_start k=%0d got=%b want=%b", k, mdu_start, k == 0);
            end
            total++;
            if (mdu_busy !== exp_busy || stall_d !== 1'b0) begin
                bad++;
                $display("FAIL mult_busy k=%0d got=%b/%b want=%b/0", k, mdu_busy, stall_d, exp_busy);
            end
            total++;
            if (mdu_op !== (exp_busy ? OP_MULT : OP_NONE)) begin
                bad++;
                $display("FAIL mult_op k=%0d got=%0d want=%0d", k, mdu_op, exp_busy ? OP_MULT : OP_NONE);
            end
            exp_c = (commit_q.size() > 0) && (commit_q[0] == cyc);
            total++;
            if (hilo_commit !== exp_c) begin
                bad++;
                $display("FAIL mult_commit k=%0d got=%b want=%b", k, hilo_commit, exp_c);
            end
            if (commit_q.size() > 0 && commit_q[0] <= cyc) void'(commit_q.pop_front());
        end
    endtask

    task automatic test_div_stall();
        logic exp_c;
        for (int k = 0; k <= DL + 1; k++) begin
            drive(k == 0, OP_DIVU, 1'b1, 1'b0);
            if (k == 0) commit_q.push_back(cyc + DL - 1);
            total++;
            if (stall_d !== (k < DL)) begin
                bad++;
                $display("FAIL divu_stall k=%0d got=%b want=%b", k, stall_d, k < DL);
            end
            total++;
            if (mdu_op !== ((k < DL) ? OP_DIVU : OP_NONE)) begin
                bad++;
                $display("FAIL divu_op k=%0d got=%0d want=%0d", k, mdu_op, (k < DL) ? OP_DIVU : OP_NONE);
            end
            exp_c = (commit_q.size() > 0) && (commit_q[0] == cyc);
            total++;
            if (hilo_commit !== exp_c) begin
                bad++;
                $display("FAIL divu_commit k=%0d got=%b want=%b", k, hilo_commit, exp_c);
            end
            if (commit_q.size() > 0 && commit_q[0] <= cyc) void'(commit_q.pop_front());
        end
        drive(1'b0, OP_NONE, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic v, du, exp_busy, exp_c;
        for (int k = 0; k <= 2 * ML; k++) begin
            v  = (k == 0) || (k == ML);
            du = (k == ML);
            drive(v, OP_MULT, du, 1'b0);
            if (v) commit_q.push_back(cyc + ML - 1);
            exp_busy = (k < 2 * ML);
            total++;
            if (mdu_start !== v || mdu_busy !== exp_busy) begin
                bad++;
                $display("FAIL b2b_start_busy k=%0d got=%b/%b want=%b/%b", k, mdu_start, mdu_busy, v, exp_busy);
            end
            total++;
            if (stall_d !== (du && exp_busy)) begin
                bad++;
                $display("FAIL b2b_stall k=%0d got=%b want=%b", k, stall_d, du && exp_busy);
            end
            exp_c = (commit_q.size() > 0) && (commit_q[0] == cyc);
            total++;
            if (hilo_commit !== exp_c) begin
                bad++;
                $display("FAIL b2b_commit k=%0d got=%b want=%b", k, hilo_commit, exp_c);
            end
            if (commit_q.size() > 0 && commit_q[0] <= cyc) void'(commit_q.pop_front());
        end
    endtask

    task automatic test_mt();
        logic       vv[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] oo[7] = '{OP_MTHI, OP_NONE, OP_MTLO, 4'hF, OP_MULT, OP_MFHI, OP_MFLO};
        logic       eh[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       el[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       exp_c;
        for (int i = 0; i < 7; i++) begin
            drive(vv[i], oo[i], 1'b0, 1'b0);
            total++;
            if (hi_we !== eh[i] || lo_we !== el[i]) begin
                bad++;
                $display("FAIL mt_we i=%0d op=%0d got=%b%b want=%b%b", i, oo[i], hi_we, lo_we, eh[i], el[i]);
            end
            total++;
            if (mdu_busy !== 1'b0 || mdu_start !== 1'b0) begin
                bad++;
                $display("FAIL mt_busy i=%0d got=%b/%b want=0/0", i, mdu_busy, mdu_start);
            end
        end
        // mthi reaching E during RUN must never be written
        for (int k = 0; k <= ML; k++) begin
            drive(k == 0 || k == 2, (k == 0) ? OP_MULT : OP_MTHI, 1'b0, 1'b0);
            if (k == 0) commit_q.push_back(cyc + ML - 1);
            if (k == 2) begin
                total++;
                if (hi_we !== 1'b0) begin
                    bad++;
                    $display("FAIL mt_in_run got=%b want=0", hi_we);
                end
            end
            exp_c = (commit_q.size() > 0) && (commit_q[0] == cyc);
            total++;
            if (hilo_commit !== exp_c) begin
                bad++;
                $display("FAIL mt_run_commit k=%0d got=%b want=%b", k, hilo_commit, exp_c);
            end
            if (commit_q.size() > 0 && commit_q[0] <= cyc) void'(commit_q.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, OP_DIV, 1'b0, 1'b0);
        drive(1'b0, OP_NONE, 1'b0, 1'b0);
        drive(1'b0, OP_NONE, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        total++;
        if (mdu_busy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre_busy got=%b want=1", mdu_busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mdu_busy !== 1'b0 || hilo_commit !== 1'b0 || mdu_op !== OP_NONE) begin
            bad++;
            $display("FAIL rstmid_async got=%b/%b/%0d want=0/0/0", mdu_busy, hilo_commit, mdu_op);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < DL; k++) begin
            drive(1'b0, OP_NONE, 1'b0, 1'b0);
            total++;
            if (hilo_commit !== 1'b0 || mdu_busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_after k=%0d got=%b/%b want=0/0", k, hilo_commit, mdu_busy);
            end
        end
    endtask

    task automatic test_cancel();
        logic exp_busy, exp_c;
        for (int k = 0; k <= ML + 1; k++) begin
            drive(k == 0, OP_MULT, 1'b0, k == ML - 1);
`ifdef MDU_CANCEL_EN
            exp_busy = (k < ML);
`else
            if (k == 0) commit_q.push_back(cyc + ML - 1);
            exp_busy = (k < ML);
`endif
            exp_c = (commit_q.size() > 0) && (commit_q[0] == cyc);
            total++;
            if (hilo_commit !== exp_c) begin
                bad++;
                $display("FAIL cancel_commit k=%0d got=%b want=%b", k, hilo_commit, exp_c);
            end
            total++;
            if (mdu_busy !== exp_busy) begin
                bad++;
                $display("FAIL cancel_busy k=%0d got=%b want=%b", k, mdu_busy, exp_busy);
            end
            if (commit_q.size() > 0 && commit_q[0] <= cyc) void'(commit_q.pop_front());
        end
        drive(1'b1, OP_MTHI, 1'b0, 1'b1);
`ifdef MDU_CANCEL_EN
        total++;
        if (hi_we !== 1'b0) begin
            bad++;
            $display("FAIL cancel_idle_mthi got=%b want=0", hi_we);
        end
        drive(1'b1, OP_MULT, 1'b0, 1'b1);
        total++;
        if (mdu_start !== 1'b0 || mdu_busy !== 1'b0) begin
            bad++;
            $display("FAIL cancel_idle_start got=%b/%b want=0/0", mdu_start, mdu_busy);
        end
`else
        total++;
        if (hi_we !== 1'b1) begin
            bad++;
            $display("FAIL cancel_ignored_mthi got=%b want=1", hi_we);
        end
`endif
        drive(1'b0, OP_NONE, 1'b0, 1'b0);
        total++;
        if (commit_q.size() != 0) begin
            bad++;
            $display("FAIL pending_commits got=%0d want=0", commit_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_stall();
        test_back_to_back();
        test_mt();
        test_reset_mid();
        test_cancel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
